seq_gen111: RTL and testbench
=============================

# seq_gen111

Serial pattern transmitter: the sending end of the overlapping "111" sequence-detector link. It accepts a WIDTH-bit pattern through a ready/start handshake and shifts it out MSB-first, one bit per clock, on a single serial line. Alongside the data it emits golden reference outputs for the downstream detector: a per-bit `mark` on every overlapping third consecutive 1, and a per-frame hit count. It sits upstream of the "111" detector in self-checking benches and in loopback test logic.

## Interface
- `WIDTH`, default 16: pattern length in bits. Legal range is 3..64.
- `CW`, default `$clog2(WIDTH+1)`: width of the hit counter.
- `clk`  in  1: single clock. Everything updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: request to send `pattern`. Sampled only when `ready`=1.
- `pattern`  in  WIDTH: frame to transmit, MSB first.
- `ready`  out  1: block can accept `start` this cycle.
- `out`  out  1: serial data bit. Registered.
- `valid`  out  1: `out` carries a frame bit this cycle.
- `last`  out  1: current bit is the final bit of the frame.
- `mark`  out  1: current `out` bit completes a "111" run. Overlapping count.
- `hit_cnt`  out  CW: number of `mark` pulses in the current or most recent frame.

## Operation
- There are two states, IDLE and SHIFT.
- On reset (`rst`=0, asynchronous):
  - state = IDLE.
  - `out`, `valid`, `last`, `mark` = 0.
  - `hit_cnt` = 0, and the run tracker = 0.
  - `ready` = 1 as soon as `rst` deasserts.
- IDLE:
  - Outputs: `ready`=1, `valid`=0, `out`=0.
  - On `start`=1, latch `pattern` into the shift register, load the bit counter with WIDTH-1, clear `hit_cnt`, and go to SHIFT.
- SHIFT:
  - Outputs: `valid`=1 and `out` = shift register MSB.
  - Each edge shifts left by one and decrements the counter.
  - `last`=1 when the counter is 0.
  - `ready`=1 only during the `last` cycle. At that cycle's edge:
    - `start`=1 starts the next frame gaplessly (stay in SHIFT, reload).
    - `start`=0 returns to IDLE.
- `start` while `ready`=0 is ignored. No queuing, no error.
- Run tracker: a saturating 0..2 count of consecutive 1s already sent.
  - `mark` = `valid & out & (run==2)`.
  - The tracker updates on each valid bit: 1 → min(run+1, 2); 0 → 0.
  - It is cleared whenever `valid`=0 (idle gap).
  - It carries across back-to-back frames with no gap.
- `hit_cnt` increments on every `mark`. It is cleared at frame accept and holds after the frame until the next accept. It cannot overflow, because WIDTH-2 < 2^CW.
- `pattern` is sampled only at the accept edge. Later changes to it have no effect.
- Reset mid-frame aborts immediately. There is no partial `last` pulse.

## Timing
- Latency: `start` accepted at edge N → first bit on `out` from edge N (cycle N+1).
- `valid` is high for exactly WIDTH cycles per frame.
- `last` coincides with bit WIDTH.
- `mark` is combinational from registered state, so it is aligned with the `out` bit it qualifies.
- `hit_cnt` is final in the cycle after `last`. The `last` cycle itself shows the count excluding that bit's mark.
- Back-to-back frames: zero idle cycles between bit WIDTH of frame k and bit 1 of frame k+1.
- Throughput: one bit per clock.

## Structure
- Shared package `seq_pkg`:
  - State enum `{IDLE, SHIFT}`.
  - Run-tracker width constant (2 bits).
  - The target-run constant `RUN_LEN = 3`, reused by the detector.
- One natural sub-module: `run_tracker`. It holds the saturating consecutive-ones counter and generates `mark`. The detector model can reuse it.
- The top level holds the FSM, the shift register, the bit counter and `hit_cnt`.

## Test plan
All scenarios use WIDTH=8. Bits are 1-based within the frame.
- Reset:
  - Stimulus: hold `rst`=0, pulse `start`.
  - Required: `ready`=1, `valid`=0, `out`=0, `hit_cnt`=0, and no frame sent.
  - Stimulus: assert `rst`=0 at frame bit 4.
  - Required: all outputs 0 the same cycle, and `ready`=1 after release.
- Single frame `8'b0111_1101`:
  - Required: `out` sequence 0,1,1,1,1,1,0,1.
  - Required: `mark` on bits 4, 5, 6; `last` on bit 8; `hit_cnt`=3.
- All ones, `8'hFF`:
  - Required: `mark` on bits 3..8, `hit_cnt`=6, `valid` high for exactly 8 cycles.
- Back-to-back versus gap, `8'h03` then `8'hC0`:
  - Stimulus: `start` held high during frame 1's `last` cycle.
  - Required: frame 2 `mark` on bits 1 and 2, frame 2 `hit_cnt`=2.
  - Stimulus: the same pair with one idle cycle between frames.
  - Required: no marks, `hit_cnt`=0.
- Handshake:
  - Stimulus: `start` pulsed at bit 3 of a frame; `pattern` changed on bit 2.
  - Required: both ignored; the frame completes with its original bits.
  - Stimulus: `start` held high continuously.
  - Required: gapless frames with `ready` high only on `last` cycles.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the "111" transmitter and the detector that consumes its stream.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int RUN_W   = 2;
    localparam int RUN_LEN = 3;

    // Value the tracker holds once RUN_LEN-1 ones have been seen; the next 1 completes a run.
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN - 1);

endpackage

// File: rtl/run_tracker.sv
// Saturating count of consecutive 1s on a qualified bit stream; flags each bit that completes a run.
module run_tracker
    import seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic bit_in,
    output logic mark
);

    logic [RUN_W-1:0] run_reg;
    logic [RUN_W-1:0] run_next;

    // An idle gap breaks the run; back-to-back valid bits keep it alive across frames.
    always_comb begin
        run_next = '0;
        if (valid && bit_in) begin
            run_next = (run_reg == RUN_MAX) ? RUN_MAX : run_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_reg <= '0;
        end else begin
            run_reg <= run_next;
        end
    end

    assign mark = valid & bit_in & (run_reg == RUN_MAX);

endmodule

// File: rtl/seq_gen111.sv
// Serial pattern transmitter: shifts a WIDTH-bit frame out MSB-first with golden "111" marks and a hit count.
module seq_gen111
    import seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    output logic             ready,
    output logic             out,
    output logic             valid,
    output logic             last,
    output logic             mark,
    output logic [CW-1:0]    hit_cnt
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] CNT_LOAD = BW'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [BW-1:0]    cnt_reg;
    logic [BW-1:0]    cnt_next;
    logic [CW-1:0]    hit_cnt_reg;
    logic [CW-1:0]    hit_cnt_next;
    logic             accept;
    logic             final_bit;

    assign final_bit = (state_reg == SHIFT) && (cnt_reg == '0);
    assign accept    = ready && start;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: a start on the final bit chains the next frame with no gap.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (final_bit) begin
                    state_next = start ? SHIFT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready = 1'b0;
        valid = 1'b0;
        out   = 1'b0;
        last  = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
            end
            SHIFT: begin
                valid = 1'b1;
                out   = shift_reg[WIDTH-1];
                last  = final_bit;
                ready = final_bit;
            end
            default: ;
        endcase
    end

    run_tracker u_run_tracker (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid),
        .bit_in (out),
        .mark   (mark)
    );

    // Datapath: the counter wraps after the final bit of a non-chained frame, which is harmless in IDLE.
    always_comb begin
        shift_next   = shift_reg;
        cnt_next     = cnt_reg;
        hit_cnt_next = hit_cnt_reg;
        if (accept) begin
            shift_next   = pattern;
            cnt_next     = CNT_LOAD;
            hit_cnt_next = '0;
        end else if (valid) begin
            shift_next = {shift_reg[WIDTH-2:0], 1'b0};
            cnt_next   = cnt_reg - 1'b1;
            if (mark) begin
                hit_cnt_next = hit_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg   <= '0;
            cnt_reg     <= '0;
            hit_cnt_reg <= '0;
        end else begin
            shift_reg   <= shift_next;
            cnt_reg     <= cnt_next;
            hit_cnt_reg <= hit_cnt_next;
        end
    end

    assign hit_cnt = hit_cnt_reg;

endmodule

// File: tb/tb_seq_gen111.sv
// Bench for seq_gen111 at WIDTH=8: directed frame table, hand-written corner sequences, random traffic vs a model.
module tb_seq_gen111;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          start   = 1'b0;
    logic [W-1:0]  pattern = '0;
    logic          ready;
    logic          out;
    logic          valid;
    logic          last;
    logic          mark;
    logic [CW-1:0] hit_cnt;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    seq_gen111 #(.WIDTH(W), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .ready   (ready),
        .out     (out),
        .valid   (valid),
        .last    (last),
        .mark    (mark),
        .hit_cnt (hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: frame bits remaining, unbounded streak of 1s since the last idle gap, hits this frame.
    logic         m_active = 1'b0;
    int           m_pos    = 0;
    logic [W-1:0] m_pat    = '0;
    int           m_streak = 0;
    int           m_hits   = 0;

    // Returns {ready, valid, out, last, mark}
    function automatic logic [4:0] model_out();
        logic v, o, l, r, mk;
        v  = m_active;
        o  = m_active ? m_pat[W-1-m_pos] : 1'b0;
        l  = m_active && (m_pos == W - 1);
        r  = !m_active || l;
        mk = v && o && (m_streak >= 2);
        return {r, v, o, l, mk};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active <= 1'b0;
            m_pos    <= 0;
            m_streak <= 0;
            m_hits   <= 0;
        end else begin
            m_streak <= (model_out() & 5'b01100) == 5'b01100 ? m_streak + 1 : 0;
            if (model_out() & 5'b00001) m_hits <= m_hits + 1;
            if (model_out() & 5'b10000 && start) begin
                m_pat    <= pattern;
                m_pos    <= 0;
                m_active <= 1'b1;
                m_hits   <= 0;
            end else if (m_active) begin
                if (model_out() & 5'b00010) m_active <= 1'b0;
                else m_pos <= m_pos + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cycle_model", {ready, valid, out, last, mark, hit_cnt}, {model_out(), m_hits[CW-1:0]});
        end
    end

    typedef struct {
        logic [W-1:0] pat;
        logic [W-1:0] exp_mark;
        int           exp_hits;
    } vec_t;

    // Samples one frame (bit 1 at the first negedge); optionally chains a next frame or disturbs the handshake.
    task automatic frame(input logic [W-1:0] pat, input bit chain, input logic [W-1:0] nxt,
                         input bit disturb, output logic [W-1:0] bits, output logic [W-1:0] marks,
                         output int vc);
        bits  = '0;
        marks = '0;
        vc    = 0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            bits[W-1-i]  = out;
            marks[W-1-i] = mark;
            if (valid) vc++;
            chk("frame_last", last, (i == W - 1));
            start = 1'b0;
            if (disturb && i == 1) pattern = ~pat;
            if (disturb && i == 2) start = 1'b1;
            if (chain && i == W - 1) begin
                start   = 1'b1;
                pattern = nxt;
            end
        end
    endtask

    initial begin
        vec_t         tbl[4];
        logic [W-1:0] bits;
        logic [W-1:0] marks;
        int           vc;
        int           waited;

        tbl[0] = '{8'h7D, 8'h1C, 3};
        tbl[1] = '{8'hFF, 8'h3F, 6};
        tbl[2] = '{8'h03, 8'h00, 0};
        tbl[3] = '{8'hC0, 8'h00, 0};
        chk_en = 1'b1;

        // Held in reset: start must not launch a frame
        start   = 1'b1;
        pattern = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_hold", {ready, valid, out, hit_cnt}, {1'b1, 1'b0, 1'b0, {CW{1'b0}}});
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_release", {ready, valid}, 2'b10);

        // Directed frames, one idle cycle apart
        for (int k = 0; k < 4; k++) begin
            start   = 1'b1;
            pattern = tbl[k].pat;
            frame(tbl[k].pat, 1'b0, '0, 1'b0, bits, marks, vc);
            chk("tbl_bits", bits, tbl[k].pat);
            chk("tbl_marks", marks, tbl[k].exp_mark);
            chk("tbl_valid_cnt", vc, W);
            @(negedge clk);
            chk("tbl_hits", hit_cnt, tbl[k].exp_hits);
            chk("tbl_idle_after", valid, 1'b0);
        end

        // Back-to-back 03 -> C0: the run carries across the frame boundary
        start   = 1'b1;
        pattern = 8'h03;
        frame(8'h03, 1'b1, 8'hC0, 1'b0, bits, marks, vc);
        chk("b2b_f1_marks", marks, 8'h00);
        frame(8'hC0, 1'b0, '0, 1'b0, bits, marks, vc);
        chk("b2b_f2_bits", bits, 8'hC0);
        chk("b2b_f2_marks", marks, 8'hC0);
        @(negedge clk);
        chk("b2b_f2_hits", hit_cnt, 2);

        // start and pattern changes while busy are ignored
        start   = 1'b1;
        pattern = 8'hA5;
        frame(8'hA5, 1'b0, '0, 1'b1, bits, marks, vc);
        chk("hs_bits", bits, 8'hA5);
        @(negedge clk);
        chk("hs_no_restart", valid, 1'b0);

        // Reset asserted during bit 4
        start   = 1'b1;
        pattern = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("midrst_outs", {valid, out, last, mark, hit_cnt}, '0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("midrst_release", {ready, valid}, 2'b10);

        // start held high: gapless frames, ready only on last
        start   = 1'b1;
        pattern = 8'($urandom);
        for (int c = 0; c < 3 * W; c++) begin
            @(negedge clk);
            pattern = 8'($urandom);
            chk("cont_valid", valid, 1'b1);
            chk("cont_last", last, (c % W == W - 1));
            chk("cont_ready", ready, last);
        end
        start  = 1'b0;
        waited = 0;
        while (valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("cont_drain", valid, 1'b0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            start   = ($urandom_range(0, 3) == 0);
            pattern = 8'($urandom);
        end
        start = 1'b0;
        repeat (2 * W) @(negedge clk);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
